mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 mux datapath (inputs i0..i3, selects s1/s0) between four requesters.
- Grants one requester at a time and drives the mux select lines.
- Holds the grant until the owner releases, drops its request, or exceeds a hold limit.
- Sits directly in front of the 4:1 mux; its sel output wires to s1/s0.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 = unlimited.
- HOLD_W, 4, hold-counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit k = mux input ik.
- done  input  4  release strobe per requester; only done[owner] is honoured.
- grant  output  4  one-hot grant, registered; all zero when no owner.
- sel  output  2  mux select; sel[1]→s1, sel[0]→s0; registered.
- busy  output  1  high while in GRANT state.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - grant=0, sel=0, busy=0, timeout=0.
  - state=IDLE, ptr=0, cnt=0.
- State IDLE:
  - If any req bit is high at a rising edge, pick the first set bit searching ptr, ptr+1, … wrapping mod 4.
  - The winner k is registered at that edge: grant=one-hot(k), sel=k, busy=1, cnt=1, state→GRANT.
  - Latency is one cycle from sampled req to visible grant.
  - If no req is high, stay in IDLE; grant=0; sel holds its last value so the mux output stays stable.
- State GRANT, owner k. Release conditions, evaluated at each edge:
  - a) done[k]=1.
  - b) req[k]=0.
  - c) MAX_HOLD≠0 and cnt==MAX_HOLD.
- On release:
  - state→IDLE, grant=0, busy=0, ptr=(k+1) mod 4, cnt=0.
  - timeout=1 for one cycle only if c) holds and neither a) nor b) holds. a) or b) take precedence.
  - The bus is idle for exactly one cycle between owners; re-arbitration happens in that IDLE cycle.
- Otherwise, while holding:
  - cnt increments, saturating at MAX_HOLD.
  - grant and sel are unchanged.
  - Requests and done from non-owners are ignored.
- Fairness:
  - A continuously requesting requester is granted within 3 other grants.
  - ptr moves only on release, never in IDLE without a grant.
- Edge cases:
  - sel wraps 3→0 for ptr.
  - Only one grant bit is ever high.
  - done asserted in IDLE is ignored.
  - MAX_HOLD=1 means every grant lasts exactly one cycle; timeout pulses unless done or req-drop coincides.

Decomposition:
- Shared package:
  - state enum {IDLE, GRANT}.
  - constant N_REQ=4.
  - constant SEL_W=2.
  - one-hot/index conversion function.
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Rotating priority encoder; unit-tested separately.
- FSM, hold counter and output registers live in mux4_rr_arbiter.

Test Plan:
- Reset mid-grant:
  - Stimulus: owner 2 granted, assert rst between clock edges.
  - Required: grant=0000, sel=00, busy=0 immediately; after rst drops with req=0100, grant=0100 one edge later.
- Single requester:
  - Stimulus: req=0001 at edge 1.
  - Required: grant=0001, sel=00 after edge 1; done[0] pulse at edge 4 → grant=0000 after edge 4, ptr=1.
- Round robin:
  - Stimulus: req=1111 held, each owner pulses done on its 2nd grant cycle.
  - Required: grant order 0001,0010,0100,1000,0001 with sel 0,1,2,3,0; one IDLE cycle between each.
- Timeout (MAX_HOLD=3):
  - Stimulus: req=0010 held, no done.
  - Required: grant=0010 for exactly 3 cycles, then timeout=1 for one cycle with grant=0000; regrant 0010 the next edge.
- Precedence:
  - Stimulus: MAX_HOLD=2, done[owner] asserted on the cycle cnt==2.
  - Required: timeout stays 0.
  - Stimulus: done[3] asserted while owner is 1.
  - Required: ignored; grant stays 0010.
- Request drop and mux integration:
  - Stimulus: owner 3 drops req[3] while req=0101.
  - Required: release, then grant=0001 (ptr=0, wrap); connect to a 4:1 mux with i0=1, others 0, and check o=1.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   state_t     : arbiter FSM states
//   N_REQ/SEL_W : requester count and mux select width
//   idx2onehot / onehot2idx : grant index <-> one-hot grant vector
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  function automatic logic [SEL_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating priority encoder: finds the first set request bit starting at
// ptr and searching ptr+1, ptr+2, ... modulo 4.
//   req   in  [3:0] request vector
//   ptr   in  [1:0] highest-priority position
//   found out       any request set
//   idx   out [1:0] winning requester (ptr when nothing is found)
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      // Two-bit addition wraps naturally, giving the mod-4 search order.
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux.
//   clk     in       rising-edge clock
//   rst     in       asynchronous active-high reset
//   req     in  [3:0] per-requester request (bit k = mux input ik)
//   done    in  [3:0] release strobe; only the owner's bit is honoured
//   grant   out [3:0] registered one-hot grant, zero when idle
//   sel     out [1:0] registered mux select (sel[1]->s1, sel[0]->s0)
//   busy    out       high while a grant is held
//   timeout out       one-cycle pulse when MAX_HOLD revokes a grant
// Handshake: a requester owns the mux from the cycle its grant bit is seen
// high until the edge where it drops req, pulses done, or reaches MAX_HOLD
// consecutive grant cycles; one idle cycle always separates owners.
// MAX_HOLD = 0 disables the hold limit. HOLD_W must satisfy 2^HOLD_W > MAX_HOLD.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              busy_nxt, timeout_nxt;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              rel_done, rel_drop, rel_hold;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While in GRANT, sel always holds the owner's index.
  assign rel_done = done[sel];
  assign rel_drop = ~req[sel];
  assign rel_hold = (MAX_HOLD != 0) && (cnt == HOLD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      grant   <= grant_nxt;
      sel     <= sel_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    sel_nxt     = sel;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        // sel is left alone when nobody requests so the mux output is stable.
        if (pick_found) begin
          state_nxt = GRANT;
          grant_nxt = idx2onehot(pick_idx);
          sel_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = sel + SEL_W'(1);
          cnt_nxt     = '0;
          // A voluntary release on the same edge is not reported as a timeout.
          timeout_nxt = rel_hold && !rel_done && !rel_drop;
        end else if (MAX_HOLD == 0) begin
          if (cnt != '1) cnt_nxt = cnt + HOLD_W'(1);
        end else if (cnt != HOLD_MAX) begin
          cnt_nxt = cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Three instances with different hold
// limits (8, 3, 2) share clock and reset; each step pushes the expected
// {grant, sel, busy, timeout} word, advances one edge and pops/compares.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, done, req_t, done_t, req_p, done_p;
  logic [3:0] grant, grant_t, grant_p;
  logic [1:0] sel, sel_t, sel_p;
  logic       busy, busy_t, busy_p;
  logic       timeout, timeout_t, timeout_p;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;

  // 4:1 mux driven by the arbiter's select: i0=1, i1..i3=0.
  logic [3:0] mux_i;
  logic       mux_o;
  assign mux_i = 4'b0001;
  assign mux_o = mux_i[sel];

  mux4_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
  );

  mux4_rr_arbiter #(.MAX_HOLD(3), .HOLD_W(4)) dut_t (
    .clk(clk), .rst(rst), .req(req_t), .done(done_t),
    .grant(grant_t), .sel(sel_t), .busy(busy_t), .timeout(timeout_t)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(4)) dut_p (
    .clk(clk), .rst(rst), .req(req_p), .done(done_p),
    .grant(grant_p), .sel(sel_p), .busy(busy_p), .timeout(timeout_p)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] s,
                                    input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  function automatic logic [7:0] obs(input int which);
    case (which)
      1:       return {grant_t, sel_t, busy_t, timeout_t};
      2:       return {grant_p, sel_p, busy_p, timeout_p};
      default: return {grant, sel, busy, timeout};
    endcase
  endfunction

  // Scoreboard
  task automatic check(input int which, input string tag);
    logic [7:0] e, o;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=no_expectation required=queued_value", tag);
    end else begin
      e = exp_q.pop_front();
      o = obs(which);
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed(g,s,b,t)=%b_%b_%b_%b required=%b_%b_%b_%b", tag,
               o[7:4], o[3:2], o[1], o[0], e[7:4], e[3:2], e[1], e[0]);
      end
    end
  endtask

  // Driver tasks
  task automatic step(input int which, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(which, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_mux(input logic e, input string tag);
    checks++;
    assert (mux_o === e) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", tag, mux_o, e);
    end
  endtask

  initial begin
    logic [3:0] g;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0; done   = '0;
    req_t  = '0; done_t = '0;
    req_p  = '0; done_p = '0;

    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
      check(w, "reset_state");
    end
    rst = 1'b0;

    // Single requester: grant after edge 1, done at edge 4 releases.
    req = 4'b0001;
    step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "single_grant");
    step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "single_hold2");
    step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "single_hold3");
    done = 4'b0001;
    step(0, ev(4'b0000, 2'd0, 1'b0, 1'b0), "single_release");
    done = 4'b0000;
    // ptr is now 1, so requester 1 beats requester 0.
    req = 4'b0011;
    step(0, ev(4'b0010, 2'd1, 1'b1, 1'b0), "ptr_after_release");
    req = 4'b0000;
    step(0, ev(4'b0000, 2'd1, 1'b0, 1'b0), "drop_release_sel_holds");
    // done while idle is ignored.
    done = 4'b1111;
    step(0, ev(4'b0000, 2'd1, 1'b0, 1'b0), "done_in_idle");
    done = 4'b0000;

    // Round robin with every owner releasing on its second grant cycle.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      g = 4'(1) << k;
      step(0, ev(g, 2'(k), 1'b1, 1'b0), "rr_grant");
      step(0, ev(g, 2'(k), 1'b1, 1'b0), "rr_grant_cycle2");
      done = g;
      step(0, ev(4'b0000, 2'(k), 1'b0, 1'b0), "rr_idle_gap");
      done = 4'b0000;
    end
    step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "rr_wrap_to_0");
    req = 4'b0000;
    step(0, ev(4'b0000, 2'd0, 1'b0, 1'b0), "rr_end");

    // Reset asserted mid-grant with owner 2.
    do_reset();
    req = 4'b0100;
    step(0, ev(4'b0100, 2'd2, 1'b1, 1'b0), "owner2_grant");
    rst = 1'b1;
    #1;
    exp_q.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
    check(0, "async_reset_mid_grant");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, ev(4'b0100, 2'd2, 1'b1, 1'b0), "regrant_after_reset");
    req = 4'b0000;
    step(0, ev(4'b0000, 2'd2, 1'b0, 1'b0), "owner2_drop");

    // Request drop by owner 3, ptr wraps to 0, mux integration.
    do_reset();
    req = 4'b1000;
    step(0, ev(4'b1000, 2'd3, 1'b1, 1'b0), "owner3_grant");
    check_mux(1'b0, "mux_o_sel3");
    req = 4'b0101;
    step(0, ev(4'b0000, 2'd3, 1'b0, 1'b0), "owner3_drop");
    step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "wrap_grant0");
    check_mux(1'b1, "mux_o_sel0");
    // Owner 0 keeps requesting: revoked after 8 cycles, then ptr=1 picks 2.
    for (int c = 0; c < 7; c++) begin
      step(0, ev(4'b0001, 2'd0, 1'b1, 1'b0), "hold8_cycle");
    end
    step(0, ev(4'b0000, 2'd0, 1'b0, 1'b1), "hold8_timeout");
    step(0, ev(4'b0100, 2'd2, 1'b1, 1'b0), "hold8_next_owner");
    req = 4'b0000;
    step(0, ev(4'b0000, 2'd2, 1'b0, 1'b0), "hold8_end");

    // MAX_HOLD=3: three grant cycles, one-cycle timeout, regrant.
    do_reset();
    req_t = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step(1, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh3_grant");
    end
    step(1, ev(4'b0000, 2'd1, 1'b0, 1'b1), "mh3_timeout");
    step(1, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh3_regrant");
    req_t = 4'b0000;
    step(1, ev(4'b0000, 2'd1, 1'b0, 1'b0), "mh3_drop");

    // MAX_HOLD=2: non-owner done ignored; owner done at cnt==2 beats timeout.
    do_reset();
    req_p = 4'b0010;
    step(2, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh2_grant");
    done_p = 4'b1000;
    step(2, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh2_foreign_done");
    done_p = 4'b0010;
    step(2, ev(4'b0000, 2'd1, 1'b0, 1'b0), "mh2_done_beats_timeout");
    done_p = 4'b0000;
    step(2, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh2_regrant");
    step(2, ev(4'b0010, 2'd1, 1'b1, 1'b0), "mh2_hold2");
    step(2, ev(4'b0000, 2'd1, 1'b0, 1'b1), "mh2_timeout");
    req_p = 4'b0000;
    step(2, ev(4'b0000, 2'd1, 1'b0, 1'b0), "mh2_idle");

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
